// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath.
//   DW      - signed operand width (input and weight words)
//   PROD_W  - full-precision product width (2*DW)
//   ACC_W   - width of the downstream neuron accumulator
//   state_t - phases of one neuron pass in the feed sequencer
package nn_pkg;

  localparam int DW     = 8;
  localparam int PROD_W = 2 * DW;
  localparam int ACC_W  = 32;

  typedef logic signed [DW-1:0]     operand_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/mac_mult_stage.sv
// Registered signed multiply with valid/last tags carried alongside the data.
//   clk, rst        - clock, synchronous active-high reset
//   vld, last       - tag of the operand pair presented this cycle
//   a, b            - signed operands
//   prod            - registered product; forced to 0 when the pair was not valid
//   prod_vld        - registered valid tag
//   prod_last       - registered last tag (only ever set together with prod_vld)
module mac_mult_stage
  import nn_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     vld,
  input  logic     last,
  input  operand_t a,
  input  operand_t b,
  output prod_t    prod,
  output logic     prod_vld,
  output logic     prod_last
);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod      <= '0;
      prod_vld  <= 1'b0;
      prod_last <= 1'b0;
    end else begin
      prod_vld  <= vld;
      prod_last <= vld && last;
      // The accumulator downstream adds prod every cycle, so an idle slot
      // must present exactly zero rather than a stale product.
      // Both operands are sign-extended first; -128*-128 fits in PROD_W.
      prod      <= vld ? prod_t'(a) * prod_t'(b) : '0;
    end
  end

endmodule

// File: rtl/mac_feed_sequencer.sv
// Upstream feed for the 32-bit neuron accumulator. On start it walks
// N_INPUTS input/weight pairs out of two sync-read memories, multiplies each
// pair and drives the product on zin, framed by acc_clr and acc_done.
//   clk, rst   - clock, synchronous active-high reset
//   start      - begin a pass; honoured in IDLE and in the acc_done cycle
//   w_base     - weight base address, captured when start is accepted
//   x_addr     - input-memory address (pair index k)
//   w_addr     - weight-memory address (w_base + k, wrapping)
//   rd_en      - read enable to both memories
//   x_data     - signed input word, one cycle after x_addr/rd_en
//   w_data     - signed weight word, one cycle after w_addr/rd_en
//   zin        - signed product to the accumulator; 0 when no product is valid
//   acc_clr    - accumulator clear pulse, first cycle of a pass
//   busy       - pass in progress
//   acc_done   - one-cycle pulse; the accumulator holds the final sum
module mac_feed_sequencer
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 16,
  parameter int DW       = nn_pkg::DW,
  parameter int XADDR_W  = 4,
  parameter int WADDR_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [WADDR_W-1:0]  w_base,
  output logic [XADDR_W-1:0]  x_addr,
  output logic [WADDR_W-1:0]  w_addr,
  output logic                rd_en,
  input  logic [DW-1:0]       x_data,
  input  logic [DW-1:0]       w_data,
  output logic [2*DW-1:0]     zin,
  output logic                acc_clr,
  output logic                busy,
  output logic                acc_done
);

  localparam logic [XADDR_W-1:0] LAST_K = XADDR_W'(N_INPUTS - 1);

  state_t               state_q, state_d;
  logic [XADDR_W-1:0]   x_addr_d;
  logic [WADDR_W-1:0]   w_addr_d;
  logic                 issue_d;
  logic                 last_d;

  // Tags travel with each read: issue_last marks the final address, the
  // _s1 copies line up with the memory data one cycle later.
  logic                 issue_last;
  logic                 vld_s1;
  logic                 last_s1;
  logic                 prod_vld;
  logic                 prod_last;

  // Next state and next address. CLEAR issues pair 0 itself, so a
  // single-pair pass goes straight to DRAIN without entering RUN.
  // NOTE: every variable gets a default at the top of the block so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    x_addr_d = x_addr;
    w_addr_d = w_addr;

    unique case (state_q)
      IDLE:    if (start) state_d = CLEAR;
      CLEAR:   state_d = (x_addr == LAST_K) ? DRAIN : RUN;
      RUN:     if (x_addr == LAST_K) state_d = DRAIN;
      // DONE follows the cycle in which the last product sits on zin.
      DRAIN:   if (prod_vld && prod_last) state_d = DONE;
      DONE:    state_d = start ? CLEAR : IDLE;
      default: state_d = IDLE;
    endcase

    unique case (state_d)
      CLEAR: begin
        x_addr_d = '0;
        w_addr_d = w_base;
      end
      RUN: begin
        x_addr_d = x_addr + XADDR_W'(1);
        w_addr_d = w_addr + WADDR_W'(1);
      end
      default: ;
    endcase

    issue_d = (state_d == CLEAR) || (state_d == RUN);
    last_d  = issue_d && (x_addr_d == LAST_K);
  end

  // All outputs are registered from the next-state decode, so each one
  // reflects the phase of the cycle it is visible in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      x_addr     <= '0;
      w_addr     <= '0;
      rd_en      <= 1'b0;
      acc_clr    <= 1'b0;
      busy       <= 1'b0;
      acc_done   <= 1'b0;
      issue_last <= 1'b0;
      vld_s1     <= 1'b0;
      last_s1    <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_addr     <= x_addr_d;
      w_addr     <= w_addr_d;
      rd_en      <= issue_d;
      acc_clr    <= (state_d == CLEAR);
      busy       <= (state_d == CLEAR) || (state_d == RUN) || (state_d == DRAIN);
      // DONE is only reachable through the last tag leaving the multiplier.
      acc_done   <= (state_d == DONE);
      issue_last <= last_d;
      vld_s1     <= rd_en;
      last_s1    <= issue_last;
    end
  end

  mac_mult_stage u_mult (
    .clk       (clk),
    .rst       (rst),
    .vld       (vld_s1),
    .last      (last_s1),
    .a         (x_data),
    .b         (w_data),
    .prod      (zin),
    .prod_vld  (prod_vld),
    .prod_last (prod_last)
  );

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// Self-checking bench for mac_feed_sequencer: a four-pair instance driven from
// a vector table, hand-written corner sequences and random passes, plus a
// single-pair instance. Expected per-cycle outputs come from the timing rules
// (cycle offsets from the accepted start) and the products/sums from plain
// integer arithmetic.
module tb_mac_feed_sequencer;
  import nn_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic string nm(input string tag, input string sig, input int c);
    return $sformatf("%s c%0d %s", tag, c, sig);
  endfunction

  // ---------------- four-pair DUT ----------------
  logic       rst, start;
  logic [7:0] w_base, w_addr;
  logic [3:0] x_addr;
  logic       rd_en, acc_clr, busy, acc_done;
  logic [7:0] x_data, w_data;
  logic [15:0] zin;

  mac_feed_sequencer #(.N_INPUTS(4), .DW(8), .XADDR_W(4), .WADDR_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .w_base(w_base),
    .x_addr(x_addr), .w_addr(w_addr), .rd_en(rd_en),
    .x_data(x_data), .w_data(w_data), .zin(zin),
    .acc_clr(acc_clr), .busy(busy), .acc_done(acc_done)
  );

  operand_t xmem [16];
  operand_t wmem [256];
  always @(posedge clk) if (rd_en) begin
    x_data <= xmem[x_addr];
    w_data <= wmem[w_addr];
  end

  // Downstream accumulator: reset by rst or acc_clr, adds zin every cycle.
  logic signed [ACC_W-1:0] acc;
  always @(posedge clk) begin
    if (rst || acc_clr) acc <= '0;
    else                acc <= acc + {{(ACC_W-16){zin[15]}}, zin};
  end

  // ---------------- single-pair DUT ----------------
  logic       start1;
  logic [7:0] w_base1, w_addr1;
  logic [0:0] x_addr1;
  logic       rd_en1, acc_clr1, busy1, acc_done1;
  logic [7:0] x_data1, w_data1;
  logic [15:0] zin1;

  mac_feed_sequencer #(.N_INPUTS(1), .DW(8), .XADDR_W(1), .WADDR_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .w_base(w_base1),
    .x_addr(x_addr1), .w_addr(w_addr1), .rd_en(rd_en1),
    .x_data(x_data1), .w_data(w_data1), .zin(zin1),
    .acc_clr(acc_clr1), .busy(busy1), .acc_done(acc_done1)
  );

  operand_t xmem1 [2];
  operand_t wmem1 [256];
  always @(posedge clk) if (rd_en1) begin
    x_data1 <= xmem1[x_addr1];
    w_data1 <= wmem1[w_addr1];
  end

  // ---------------- vector table ----------------
  typedef struct {
    operand_t   x [4];
    operand_t   w [4];
    logic [7:0] base;
    int         exp_sum;
  } vec_t;

  vec_t tbl [3];

  // One complete pass on the four-pair DUT, checked cycle by cycle.
  // Entered at mid-cycle (negedge); start is raised for cycle c0.
  task automatic run_pass(input string tag, input operand_t x [4], input operand_t w [4],
                          input logic [7:0] base, input int exp_sum);
    int prod_m [4];
    for (int k = 0; k < 4; k++) begin
      int xv, wv;
      xv = x[k];
      wv = w[k];
      xmem[k]            = x[k];
      wmem[8'(base + k)] = w[k];
      prod_m[k]          = xv * wv;
    end
    start  = 1'b1;
    w_base = base;
    @(negedge clk);
    start  = 1'b0;
    w_base = 8'($urandom);
    for (int c = 1; c <= 7; c++) begin
      check(nm(tag, "acc_clr", c), acc_clr, (c == 1));
      check(nm(tag, "rd_en", c), rd_en, (c <= 4));
      if (c <= 4) begin
        check(nm(tag, "x_addr", c), x_addr, c - 1);
        check(nm(tag, "w_addr", c), w_addr, (int'(base) + c - 1) & 255);
      end
      check(nm(tag, "zin", c), $signed(zin), (c >= 3 && c <= 6) ? prod_m[c-3] : 0);
      check(nm(tag, "busy", c), busy, (c <= 6));
      check(nm(tag, "acc_done", c), acc_done, (c == 7));
      if (c == 7) check(nm(tag, "accum", c), acc, exp_sum);
      else        @(negedge clk);
    end
  endtask

  initial begin
    tbl[0].x = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    tbl[0].w = '{8'sd5, -8'sd6, 8'sd7, -8'sd8};
    tbl[0].base = 8'h00;  tbl[0].exp_sum = -18;
    tbl[1].x = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
    tbl[1].w = '{-8'sd128, -8'sd128, -8'sd128, -8'sd128};
    tbl[1].base = 8'h40;  tbl[1].exp_sum = 65536;
    tbl[2].x = '{8'sd1, 8'sd1, 8'sd1, 8'sd1};
    tbl[2].w = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
    tbl[2].base = 8'hFE;  tbl[2].exp_sum = 10;

    // Garbage everywhere so a wrong address shows up as a wrong product.
    for (int i = 0; i < 256; i++) begin
      wmem[i]  = operand_t'($urandom);
      wmem1[i] = operand_t'($urandom);
    end
    for (int i = 0; i < 16; i++) xmem[i] = operand_t'($urandom);

    rst = 1'b1; start = 1'b0; w_base = '0; start1 = 1'b0; w_base1 = '0;
    repeat (3) @(negedge clk);
    check("reset x_addr", x_addr, 0);
    check("reset w_addr", w_addr, 0);
    check("reset rd_en", rd_en, 0);
    check("reset zin", zin, 0);
    check("reset acc_clr", acc_clr, 0);
    check("reset busy", busy, 0);
    check("reset acc_done", acc_done, 0);
    check("reset1 busy", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven passes: basic sum, extreme operands, weight address wrap.
    for (int i = 0; i < 3; i++) begin
      run_pass($sformatf("tbl%0d", i), tbl[i].x, tbl[i].w, tbl[i].base, tbl[i].exp_sum);
      repeat (2) @(negedge clk);
    end

    // Single pair on the N=1 instance: x=3, w=-2.
    xmem1[0] = 8'sd3;
    wmem1[8'h10] = -8'sd2;
    start1 = 1'b1; w_base1 = 8'h10;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      check(nm("n1", "acc_clr", c), acc_clr1, (c == 1));
      check(nm("n1", "rd_en", c), rd_en1, (c == 1));
      check(nm("n1", "zin", c), $signed(zin1), (c == 3) ? -6 : 0);
      check(nm("n1", "busy", c), busy1, (c <= 3));
      check(nm("n1", "acc_done", c), acc_done1, (c == 4));
      @(negedge clk);
    end

    // start held high: starts while busy are ignored, the one in the
    // acc_done cycle is taken as a back-to-back pass.
    for (int k = 0; k < 4; k++) begin
      xmem[k] = tbl[0].x[k];
      wmem[k] = tbl[0].w[k];
    end
    start = 1'b1; w_base = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      check(nm("hold", "acc_clr", c), acc_clr, (c == 1 || c == 8));
      check(nm("hold", "acc_done", c), acc_done, (c == 7 || c == 14));
      check(nm("hold", "busy", c), busy, ((c >= 1 && c <= 6) || (c >= 8 && c <= 13)));
      if (c == 7 || c == 14) check(nm("hold", "accum", c), acc, -18);
      start = (c < 14);
    end
    repeat (2) @(negedge clk);

    // Reset in c4 of a pass: outputs return to reset values in c5 and the
    // aborted pass never signals acc_done.
    start = 1'b1; w_base = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort x_addr", x_addr, 0);
    check("abort w_addr", w_addr, 0);
    check("abort rd_en", rd_en, 0);
    check("abort zin", zin, 0);
    check("abort acc_clr", acc_clr, 0);
    check("abort busy", busy, 0);
    check("abort acc_done", acc_done, 0);
    rst = 1'b0;
    for (int c = 6; c <= 11; c++) begin
      @(negedge clk);
      check(nm("abort", "acc_done", c), acc_done, 0);
      check(nm("abort", "zin", c), zin, 0);
      check(nm("abort", "busy", c), busy, 0);
    end
    run_pass("after_abort", tbl[0].x, tbl[0].w, tbl[0].base, tbl[0].exp_sum);
    @(negedge clk);

    // Random passes against the arithmetic model.
    for (int r = 0; r < 12; r++) begin
      operand_t   rx [4];
      operand_t   rw [4];
      logic [7:0] rb;
      int         sum, xv, wv;
      sum = 0;
      rb  = 8'($urandom);
      for (int k = 0; k < 4; k++) begin
        rx[k] = operand_t'($urandom);
        rw[k] = operand_t'($urandom);
        xv = rx[k];
        wv = rw[k];
        sum += xv * wv;
      end
      run_pass($sformatf("rnd%0d", r), rx, rw, rb, sum);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
